// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = 9'b11111_0000;
  localparam pipe_ctl_t CTL_BRANCH = 9'b11111_1110;
  localparam pipe_ctl_t CTL_BUBBLE = 9'b00111_0100;
  localparam pipe_ctl_t CTL_STALL  = 9'b00001_0001;
  localparam pipe_ctl_t CTL_RESET  = 9'b00000_1111;
  localparam pipe_ctl_t CTL_HALT   = 9'b00000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/ready handshake between the
// hazard controller (master) and the data memory (slave).
interface pipe_hazard_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output dmem_req,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    output dmem_ready
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the ID
// source operands and the load destination in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_to_reg,
  output logic       load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_uses_rs2 && (id_rs2 == ex_rd);

  assign load_use = ex_mem_to_reg
                 && (ex_rd != REG_X0)
                 && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush controller: branch flush, dmem wait
// with timeout, load-use bubble. Optional PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_to_reg,
  input  logic              mem_access,
  input  logic              mem_do_branch,
  pipe_hazard_ctrl_if.master dmem,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              mem_timeout,
  output logic [1:0]        state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_LIMIT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  pipe_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  pipe_ctl_t         ctl_core;
  pipe_ctl_t         ctl;
  logic              req_core;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_to_reg (ex_mem_to_reg),
    .load_use      (load_use)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ctl_core = CTL_RUN;
    req_core = mem_access && !mem_do_branch;
    unique case (state_q)
      RUN: begin
        if (mem_do_branch) begin
          ctl_core = CTL_BRANCH;
        end else if (mem_access && !dmem.dmem_ready) begin
          ctl_core = CTL_STALL;
          state_d  = MEM_WAIT;
          wcnt_d   = WCNT_ONE;
        end else if (load_use) begin
          ctl_core = CTL_BUBBLE;
        end
      end
      MEM_WAIT: begin
        // Branch here is a protocol violation and is ignored.
        req_core = 1'b1;
        if (dmem.dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          ctl_core = CTL_STALL;
          if (wcnt_q == WCNT_MAX) state_d = HALT;
          else                    wcnt_d  = wcnt_q + WCNT_ONE;
        end
      end
      HALT: begin
        ctl_core = CTL_HALT;
        req_core = 1'b0;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Reset overrides everything, combinationally.
  assign ctl = reset_n ? ctl_core : CTL_RESET;
  assign dmem.dmem_req = reset_n && req_core;

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign id_ex_en     = ctl.id_ex_en;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;

  assign mem_timeout = (state_q == HALT);
  assign state       = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!ctl_core.pc_en && state_q != HALT && !(&stall_q))
      stall_d = stall_q + 1'b1;
    if (mem_do_branch && state_q == RUN && !(&flush_q))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule
